// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the writeback collector.
// wb_entry_t is the default-width queue entry {wr_en, rd, data}.
package wb_arbiter_pkg;

  localparam int REG_WIDTH  = 5;
  localparam int DATA_WIDTH = 32;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  typedef struct packed {
    logic                  wr_en;
    logic [REG_WIDTH-1:0]  rd;
    logic [DATA_WIDTH-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_chan_fifo.sv
// Per-channel result queue: power-of-two ring buffer whose head is readable
// combinationally so a request can be raised the cycle after an enqueue.
module wb_chan_fifo #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_reg[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback collector: one queue per execution channel, a round-robin or
// fixed-priority arbiter, and a registered register-file write port.
module wb_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int REG_WIDTH  = 5,
  parameter int DATA_WIDTH = 32,
  parameter int ARB_MODE   = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            ch_valid,
  output logic [NUM_CH-1:0]            ch_ready,
  input  logic [NUM_CH-1:0]            ch_wr_en,
  input  logic [NUM_CH*REG_WIDTH-1:0]  ch_rd,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
  output logic                         wb_wr_en,
  output logic [REG_WIDTH-1:0]         wb_rd,
  output logic [DATA_WIDTH-1:0]        wb_wr_data,
  output logic [NUM_CH-1:0]            wb_grant,
  output logic                         wb_idle
);
  import wb_arbiter_pkg::*;

  localparam int PW = $clog2(NUM_CH);
  localparam int EW = 1 + REG_WIDTH + DATA_WIDTH;

  typedef struct packed {
    logic                  wr_en;
    logic [REG_WIDTH-1:0]  rd;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t              head [NUM_CH];
  logic [NUM_CH-1:0]   full;
  logic [NUM_CH-1:0]   empty;
  logic [NUM_CH-1:0]   push;
  logic [NUM_CH-1:0]   req;
  logic [NUM_CH-1:0]   grant;
  logic                found;
  logic [PW-1:0]       gidx;
  logic [PW:0]         cand;

  logic [PW-1:0]         ptr_reg;
  logic                  wb_wr_en_reg;
  logic [REG_WIDTH-1:0]  wb_rd_reg;
  logic [DATA_WIDTH-1:0] wb_wr_data_reg;
  logic [NUM_CH-1:0]     wb_grant_reg;
  logic                  wb_idle_reg;

  // Ready comes from registered occupancy only; a full queue never passes through.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      entry_t din;
      assign din.wr_en    = ch_wr_en[gi];
      assign din.rd       = ch_rd[gi*REG_WIDTH +: REG_WIDTH];
      assign din.data     = ch_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign ch_ready[gi] = rst && !full[gi];
      assign push[gi]     = ch_valid[gi] && ch_ready[gi];
      assign req[gi]      = !empty[gi];

      wb_chan_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push[gi]),
        .pop   (grant[gi]),
        .din   (din),
        .full  (full[gi]),
        .empty (empty[gi]),
        .head  (head[gi])
      );
    end
  endgenerate

  // Round-robin scans from the pointer with wrap; fixed priority scans from 0.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ARB_MODE == ARB_RR) begin
        cand = {1'b0, ptr_reg} + (PW+1)'(k);
        if (cand >= (PW+1)'(NUM_CH)) cand = cand - (PW+1)'(NUM_CH);
      end else begin
        cand = (PW+1)'(k);
      end
      if (!found && req[cand[PW-1:0]]) begin
        found = 1'b1;
        gidx  = cand[PW-1:0];
      end
    end
    if (found) grant[gidx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_reg        <= '0;
      wb_wr_en_reg   <= 1'b0;
      wb_rd_reg      <= '0;
      wb_wr_data_reg <= '0;
      wb_grant_reg   <= '0;
      wb_idle_reg    <= 1'b1;
    end else begin
      wb_idle_reg <= (&empty) && !wb_wr_en_reg;
      if (found) begin
        // x0 destinations are consumed without a register-file write.
        wb_wr_en_reg   <= head[gidx].wr_en && (head[gidx].rd != '0);
        wb_rd_reg      <= head[gidx].rd;
        wb_wr_data_reg <= head[gidx].data;
        wb_grant_reg   <= grant;
        if (ARB_MODE == ARB_RR)
          ptr_reg <= (gidx == PW'(NUM_CH-1)) ? '0 : gidx + 1'b1;
      end else begin
        wb_wr_en_reg <= 1'b0;
        wb_grant_reg <= '0;
      end
    end
  end

  assign wb_wr_en   = wb_wr_en_reg;
  assign wb_rd      = wb_rd_reg;
  assign wb_wr_data = wb_wr_data_reg;
  assign wb_grant   = wb_grant_reg;
  assign wb_idle    = wb_idle_reg;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: a round-robin and a fixed-priority instance share
// stimulus and are checked against a queue-based reference model each cycle.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int D  = 2;
  localparam int RW = 5;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    ch_valid = '0;
  logic [N-1:0]    ch_wr_en = '0;
  logic [N*RW-1:0] ch_rd    = '0;
  logic [N*DW-1:0] ch_data  = '0;

  logic [N-1:0]  o_ready [2];
  logic          o_wr    [2];
  logic [RW-1:0] o_rd    [2];
  logic [DW-1:0] o_data  [2];
  logic [N-1:0]  o_grant [2];
  logic          o_idle  [2];

  wb_arbiter #(.NUM_CH(N), .FIFO_DEPTH(D), .REG_WIDTH(RW), .DATA_WIDTH(DW), .ARB_MODE(ARB_RR)) dut_rr (
    .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_ready(o_ready[0]), .ch_wr_en(ch_wr_en),
    .ch_rd(ch_rd), .ch_data(ch_data), .wb_wr_en(o_wr[0]), .wb_rd(o_rd[0]),
    .wb_wr_data(o_data[0]), .wb_grant(o_grant[0]), .wb_idle(o_idle[0]));

  wb_arbiter #(.NUM_CH(N), .FIFO_DEPTH(D), .REG_WIDTH(RW), .DATA_WIDTH(DW), .ARB_MODE(ARB_FIXED)) dut_fx (
    .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_ready(o_ready[1]), .ch_wr_en(ch_wr_en),
    .ch_rd(ch_rd), .ch_data(ch_data), .wb_wr_en(o_wr[1]), .wb_rd(o_rd[1]),
    .wb_wr_data(o_data[1]), .wb_grant(o_grant[1]), .wb_idle(o_idle[1]));

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: model 0 is round-robin, model 1 is fixed priority.
  wb_entry_t     mq [2*N][$];
  int            m_ptr   [2];
  bit            m_wr    [2];
  bit [RW-1:0]   m_rd    [2];
  bit [DW-1:0]   m_data  [2];
  bit [N-1:0]    m_grant [2];
  bit            m_idle  [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_step(input int m);
    int        g;
    bit        all_empty;
    bit        new_idle;
    bit [N-1:0] rdy;
    wb_entry_t e;
    if (!rst) begin
      for (int i = 0; i < N; i++) mq[m*N+i].delete();
      m_ptr[m] = 0; m_wr[m] = 0; m_rd[m] = '0; m_data[m] = '0; m_grant[m] = '0; m_idle[m] = 1;
      return;
    end
    all_empty = 1;
    for (int i = 0; i < N; i++) begin
      if (mq[m*N+i].size() != 0) all_empty = 0;
      rdy[i] = (mq[m*N+i].size() < D);
    end
    new_idle = all_empty && !m_wr[m];
    g = -1;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m == 0) ? (m_ptr[m] + k) % N : k;
      if (g < 0 && mq[m*N+c].size() > 0) g = c;
    end
    if (g >= 0) begin
      e = mq[m*N+g].pop_front();
      m_wr[m]   = e.wr_en && (e.rd != 0);
      m_rd[m]   = e.rd;
      m_data[m] = e.data;
      m_grant[m] = '0;
      m_grant[m][g] = 1'b1;
      if (m == 0) m_ptr[m] = (g + 1) % N;
    end else begin
      m_wr[m] = 0;
      m_grant[m] = '0;
    end
    for (int i = 0; i < N; i++) begin
      if (ch_valid[i] && rdy[i]) begin
        e.wr_en = ch_wr_en[i];
        e.rd    = ch_rd[i*RW +: RW];
        e.data  = ch_data[i*DW +: DW];
        mq[m*N+i].push_back(e);
      end
    end
    m_idle[m] = new_idle;
  endtask

  task automatic cmp_models();
    bit [N-1:0] er;
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < N; i++) er[i] = rst && (mq[m*N+i].size() < D);
      chk($sformatf("m%0d ch_ready", m), o_ready[m], er);
      chk($sformatf("m%0d wb_wr_en", m), o_wr[m], m_wr[m]);
      chk($sformatf("m%0d wb_rd", m), o_rd[m], m_rd[m]);
      chk($sformatf("m%0d wb_wr_data", m), o_data[m], m_data[m]);
      chk($sformatf("m%0d wb_grant", m), o_grant[m], m_grant[m]);
      chk($sformatf("m%0d wb_idle", m), o_idle[m], m_idle[m]);
    end
  endtask

  task automatic cycle(input bit cmp);
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    if (cmp) cmp_models();
  endtask

  task automatic set_ch(input int i, input bit v, input bit w, input bit [RW-1:0] rd, input bit [DW-1:0] d);
    ch_valid[i] = v;
    ch_wr_en[i] = w;
    ch_rd[i*RW +: RW] = rd;
    ch_data[i*DW +: DW] = d;
  endtask

  task automatic clear_inputs();
    ch_valid = '0; ch_wr_en = '0; ch_rd = '0; ch_data = '0;
  endtask

  typedef struct {
    bit         rst;
    bit [N-1:0] valid;
    bit [N-1:0] wr;
    bit [RW-1:0] base;
    bit [DW-1:0] data;
    bit [N-1:0] e_ready;
    bit         e_wr;
    bit [RW-1:0] e_rd;
    bit [DW-1:0] e_data;
    bit [N-1:0] e_grant;
    bit         e_idle;
  } vec_t;

  vec_t        tbl [19];
  int          pushed;
  bit          fire1;
  logic [DW-1:0] obs [$];

  initial begin
    // Reset hold, single push latency, 4-way conflict, x0 suppression.
    tbl[0]  = '{0, 4'hF, 4'hF, 5'd1, 32'h1000,     4'h0, 0, 5'd0, 32'h0,        4'h0, 1};
    tbl[1]  = '{0, 4'hF, 4'hF, 5'd1, 32'h1000,     4'h0, 0, 5'd0, 32'h0,        4'h0, 1};
    tbl[2]  = '{1, 4'h0, 4'h0, 5'd0, 32'h0,        4'hF, 0, 5'd0, 32'h0,        4'h0, 1};
    tbl[3]  = '{1, 4'h1, 4'hF, 5'd3, 32'hDEADBEEF, 4'hF, 0, 5'd0, 32'h0,        4'h0, 1};
    tbl[4]  = '{1, 4'h0, 4'h0, 5'd0, 32'h0,        4'hF, 1, 5'd3, 32'hDEADBEEF, 4'h1, 0};
    tbl[5]  = '{1, 4'h0, 4'h0, 5'd0, 32'h0,        4'hF, 0, 5'd3, 32'hDEADBEEF, 4'h0, 0};
    tbl[6]  = '{1, 4'h0, 4'h0, 5'd0, 32'h0,        4'hF, 0, 5'd3, 32'hDEADBEEF, 4'h0, 1};
    tbl[7]  = '{0, 4'h0, 4'h0, 5'd0, 32'h0,        4'h0, 0, 5'd0, 32'h0,        4'h0, 1};
    tbl[8]  = '{1, 4'hF, 4'hF, 5'd1, 32'hA0,       4'hF, 0, 5'd0, 32'h0,        4'h0, 1};
    tbl[9]  = '{1, 4'h0, 4'h0, 5'd0, 32'h0,        4'hF, 1, 5'd1, 32'hA0,       4'h1, 0};
    tbl[10] = '{1, 4'h0, 4'h0, 5'd0, 32'h0,        4'hF, 1, 5'd2, 32'hA1,       4'h2, 0};
    tbl[11] = '{1, 4'h0, 4'h0, 5'd0, 32'h0,        4'hF, 1, 5'd3, 32'hA2,       4'h4, 0};
    tbl[12] = '{1, 4'h0, 4'h0, 5'd0, 32'h0,        4'hF, 1, 5'd4, 32'hA3,       4'h8, 0};
    tbl[13] = '{1, 4'h0, 4'h0, 5'd0, 32'h0,        4'hF, 0, 5'd4, 32'hA3,       4'h0, 0};
    tbl[14] = '{1, 4'h0, 4'h0, 5'd0, 32'h0,        4'hF, 0, 5'd4, 32'hA3,       4'h0, 1};
    tbl[15] = '{1, 4'h1, 4'h1, 5'd0, 32'h55,       4'hF, 0, 5'd4, 32'hA3,       4'h0, 1};
    tbl[16] = '{1, 4'h1, 4'h0, 5'd7, 32'h66,       4'hF, 0, 5'd0, 32'h55,       4'h1, 0};
    tbl[17] = '{1, 4'h0, 4'h0, 5'd0, 32'h0,        4'hF, 0, 5'd7, 32'h66,       4'h1, 0};
    tbl[18] = '{1, 4'h0, 4'h0, 5'd0, 32'h0,        4'hF, 0, 5'd7, 32'h66,       4'h0, 1};

    for (int r = 0; r < 19; r++) begin
      rst = tbl[r].rst;
      for (int i = 0; i < N; i++)
        set_ch(i, tbl[r].valid[i], tbl[r].wr[i], tbl[r].base + RW'(i), tbl[r].data + DW'(i));
      cycle(0);
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("tbl%0d m%0d ready", r, m), o_ready[m], tbl[r].e_ready);
        chk($sformatf("tbl%0d m%0d wr_en", r, m), o_wr[m], tbl[r].e_wr);
        chk($sformatf("tbl%0d m%0d rd", r, m), o_rd[m], tbl[r].e_rd);
        chk($sformatf("tbl%0d m%0d data", r, m), o_data[m], tbl[r].e_data);
        chk($sformatf("tbl%0d m%0d grant", r, m), o_grant[m], tbl[r].e_grant);
        chk($sformatf("tbl%0d m%0d idle", r, m), o_idle[m], tbl[r].e_idle);
      end
      $display("vector %0d applied: valid=%h grant_rr=%h grant_fx=%h", r, tbl[r].valid, o_grant[0], o_grant[1]);
    end

    // Backpressure: ch0 kept busy, ch1 pushes three entries.
    clear_inputs(); rst = 0; cycle(1); rst = 1;
    pushed = 0; obs.delete();
    for (int c = 0; c < 20; c++) begin
      clear_inputs();
      if (c < 8) set_ch(0, 1, 1, 5'd20, 32'h200 + c);
      if (pushed < 3) set_ch(1, 1, 1, 5'd21, 32'h100 + pushed);
      fire1 = (pushed < 3) && (mq[N+1].size() < D);
      cycle(1);
      if (fire1) pushed++;
      if (fire1 && pushed == 2) chk("bp ready1 after 2nd push", o_ready[1][1], 1'b0);
      if (c <= 8) chk("bp ch1 granted while ch0 busy", o_grant[1][1], 1'b0);
      if (o_grant[1] == 4'b0010) obs.push_back(o_data[1]);
    end
    chk("bp ch1 retire count", obs.size(), 3);
    for (int k = 0; k < 3 && k < obs.size(); k++)
      chk($sformatf("bp ch1 order %0d", k), obs[k], 32'h100 + k);
    $display("backpressure sequence: ch1 retired %0d entries", obs.size());

    // Mid-operation reset drops everything queued.
    clear_inputs();
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < N; i++) set_ch(i, 1, 1, RW'(i + 1), 32'h300 + 4 * c + i);
      cycle(1);
    end
    rst = 0; cycle(1); rst = 1; clear_inputs();
    for (int c = 0; c < 4; c++) begin
      cycle(1);
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("rst m%0d wr_en", m), o_wr[m], 1'b0);
        chk($sformatf("rst m%0d grant", m), o_grant[m], '0);
        chk($sformatf("rst m%0d idle", m), o_idle[m], 1'b1);
      end
    end
    $display("mid-operation reset sequence done");

    // Fixed priority starvation: ch0 and ch2 always valid.
    rst = 0; cycle(1); rst = 1;
    for (int c = 0; c < 12; c++) begin
      clear_inputs();
      set_ch(0, 1, 1, 5'd5, 32'h400 + c);
      set_ch(2, 1, 1, 5'd6, 32'h500 + c);
      cycle(1);
      if (c >= 1) chk("fixed grant ch0", o_grant[1], 4'b0001);
    end
    $display("fixed priority sequence done");

    // Randomized traffic with occasional resets.
    rst = 0; clear_inputs(); cycle(1);
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 63) != 0);
      for (int i = 0; i < N; i++)
        set_ch(i, $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
               RW'($urandom_range(0, 7)), $urandom);
      cycle(1);
      if (c % 100 == 0)
        $display("random cycle %0d: grant_rr=%h grant_fx=%h", c, o_grant[0], o_grant[1]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
